vga_timing_gen: RTL

Parametrised VGA raster timing generator. It replaces the fixed 640x480 sync generator and the external clock tap. It runs on board_clk with an internal pixel clock-enable prescaler, so all downstream pixel logic shares one clock domain. It provides programmable porch, sync and polarity timing, enable/pause, and frame, line and vblank strobes for the game state machine and the renderer.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen_pix_ce_div.sv | 27 ++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and derivation helpers.
package vga_timing_pkg;

  // 640x480@60 default raster timing
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Sync polarity encodings
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Prescaler state width; a divide-by-1 still keeps a 1-bit (constant) register
  function automatic int unsigned div_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the generator (master) and its consumers (slave).
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned FRAME_W = 8
);
  logic               enable;
  logic               pix_ce;
  logic               h_sync;
  logic               v_sync;
  logic               display_en;
  logic [CNT_W-1:0]   pixel_x;
  logic [CNT_W-1:0]   pixel_y;
  logic               line_start;
  logic               frame_start;
  logic               vblank_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  enable,
    output pix_ce, h_sync, v_sync, display_en, pixel_x, pixel_y,
           line_start, frame_start, vblank_start, frame_count
  );

  modport slave (
    output enable,
    input  pix_ce, h_sync, v_sync, display_en, pixel_x, pixel_y,
           line_start, frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_pix_ce_div.sv
// Pixel clock-enable prescaler: one tick every PIX_DIV enabled board_clk cycles.
module pix_ce_div
  import vga_timing_pkg::*;
#(
  parameter  int unsigned PIX_DIV = 2,
  localparam int unsigned DIV_W   = div_width(PIX_DIV)
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic             enable,
  output logic             tick,
  output logic [DIV_W-1:0] div
);

  assign tick = enable && (div == DIV_W'(PIX_DIV - 1));

  // Phase counter; holds while disabled so the remaining phase survives a pause
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (enable) begin
      if (tick) div <= '0;
      else      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with internal pixel clock-enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter bit          H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit          V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input logic              board_clk,
  input logic              reset,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W    = div_width(PIX_DIV);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic             tick;
  logic [DIV_W-1:0] div;

  logic [CNT_W-1:0]   px, py, x_next, y_next;
  logic [CNT_W:0]     xw, yw;
  logic               x_wrap, h_act, v_act, de_next;
  logic               pce, hs, vs, de, ls, fs, vbs;
  logic [FRAME_W-1:0] fc;

  pix_ce_div #(.PIX_DIV(PIX_DIV)) u_div (
    .board_clk (board_clk),
    .reset     (reset),
    .enable    (vid.enable),
    .tick      (tick),
    .div       (div)
  );

  // Next raster position and its decode; compares are one bit wider so a
  // boundary equal to 2^CNT_W cannot truncate to zero
  always_comb begin
    x_wrap  = (px == CNT_W'(H_TOTAL - 1));
    x_next  = x_wrap ? '0 : px + 1'b1;
    y_next  = py;
    if (x_wrap) y_next = (py == CNT_W'(V_TOTAL - 1)) ? '0 : py + 1'b1;
    xw      = {1'b0, x_next};
    yw      = {1'b0, y_next};
    h_act   = (xw >= (CNT_W+1)'(HS_START)) && (xw < (CNT_W+1)'(HS_END));
    v_act   = (yw >= (CNT_W+1)'(VS_START)) && (yw < (CNT_W+1)'(VS_END));
    de_next = (xw < (CNT_W+1)'(H_ACTIVE)) && (yw < (CNT_W+1)'(V_ACTIVE));
  end

  // Raster counters and all outputs load together on a tick; strobes self-clear
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      px  <= CNT_W'(H_TOTAL - 1);
      py  <= CNT_W'(V_TOTAL - 1);
      fc  <= '1;
      pce <= 1'b0;
      de  <= 1'b0;
      hs  <= ~H_SYNC_POL;
      vs  <= ~V_SYNC_POL;
      ls  <= 1'b0;
      fs  <= 1'b0;
      vbs <= 1'b0;
    end else begin
      pce <= tick;
      if (tick) begin
        px  <= x_next;
        py  <= y_next;
        de  <= de_next;
        hs  <= h_act ~^ H_SYNC_POL;
        vs  <= v_act ~^ V_SYNC_POL;
        ls  <= (x_next == '0);
        fs  <= (x_next == '0) && (y_next == '0);
        vbs <= (x_next == '0) && (yw == (CNT_W+1)'(V_ACTIVE));
        if ((x_next == '0) && (y_next == '0)) fc <= fc + 1'b1;
      end else begin
        ls  <= 1'b0;
        fs  <= 1'b0;
        vbs <= 1'b0;
      end
    end
  end

  assign vid.pix_ce       = pce;
  assign vid.h_sync       = hs;
  assign vid.v_sync       = vs;
  assign vid.display_en   = de;
  assign vid.pixel_x      = px;
  assign vid.pixel_y      = py;
  assign vid.line_start   = ls;
  assign vid.frame_start  = fs;
  assign vid.vblank_start = vbs;
  assign vid.frame_count  = fc;

  // Prescaler phase stays in range and is frozen while disabled
  a_div_range: assert property (@(posedge board_clk) disable iff (reset)
    int'(div) < int'(PIX_DIV));
  a_div_hold: assert property (@(posedge board_clk) disable iff (reset)
    !vid.enable |=> $stable(div));

endmodule
